// File: rtl/column_parallel_bank_if.sv
// Bus between the memory-controller write side, the PE-array read side and column_parallel_bank.
// With COLUMN_PARALLEL_ERR_EN defined, sticky ovf/udf error flags are added.
interface column_parallel_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_COL    = 4
);
  logic                                mode;
  logic                                clear;
  logic [NUM_COL-1:0]                  wr_req;
  logic [NUM_COL*DATA_WIDTH-1:0]       wr_data;
  logic                                rd_en;
  logic [NUM_COL-1:0]                  rd_req;
  logic [NUM_COL*DATA_WIDTH-1:0]       rd_data;
  logic [NUM_COL-1:0]                  rd_valid;
  logic [NUM_COL-1:0]                  full;
  logic [NUM_COL-1:0]                  empty;
  logic [NUM_COL*(ADDR_WIDTH+1)-1:0]   count;
`ifdef COLUMN_PARALLEL_ERR_EN
  logic [NUM_COL-1:0]                  ovf;
  logic [NUM_COL-1:0]                  udf;

  modport master (
    output mode, clear, wr_req, wr_data, rd_en, rd_req,
    input  rd_data, rd_valid, full, empty, count, ovf, udf
  );
  modport slave (
    input  mode, clear, wr_req, wr_data, rd_en, rd_req,
    output rd_data, rd_valid, full, empty, count, ovf, udf
  );
`else
  modport master (
    output mode, clear, wr_req, wr_data, rd_en, rd_req,
    input  rd_data, rd_valid, full, empty, count
  );
  modport slave (
    input  mode, clear, wr_req, wr_data, rd_en, rd_req,
    output rd_data, rd_valid, full, empty, count
  );
`endif
endinterface

// File: rtl/column_parallel_bank.sv
// NUM_COL independent circular queues feeding the PE array, with lock-step broadcast mode.
// Optional sticky overflow/underflow flags are enabled by defining COLUMN_PARALLEL_ERR_EN.
module column_parallel_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_COL    = 4
) (
  input logic                    clk_i,
  input logic                    reset_ni,
  column_parallel_bank_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [NUM_COL-1:0]            full_w;
  logic [NUM_COL-1:0]            empty_w;
  logic [NUM_COL-1:0]            wr_hit;
  logic [NUM_COL-1:0]            rd_hit;
  logic [NUM_COL-1:0]            wr_acc;
  logic [NUM_COL-1:0]            rd_acc;
  logic [NUM_COL-1:0]            rd_valid_q;
  logic [NUM_COL*DATA_WIDTH-1:0] rd_data_w;
  logic [NUM_COL*CW-1:0]         count_w;
  logic                          all_room;
  logic                          all_avail;

  // Lock-step decisions need every column to agree.
  assign all_room  = ~|full_w;
  assign all_avail = ~|empty_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COL; gi++) begin : g_col
      logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
      logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]         cnt_q, cnt_d;
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] ram_rd_q;
      logic [DATA_WIDTH-1:0] lane_wdata;

      assign full_w[gi]  = (cnt_q == CW'(DEPTH));
      assign empty_w[gi] = (cnt_q == '0);

      assign wr_hit[gi] = bus.mode ? bus.wr_req[0] : bus.wr_req[gi];
      assign rd_hit[gi] = bus.rd_en & (bus.mode ? bus.rd_req[0] : bus.rd_req[gi]);
      assign wr_acc[gi] = ~bus.clear & wr_hit[gi] & (bus.mode ? all_room  : ~full_w[gi]);
      assign rd_acc[gi] = ~bus.clear & rd_hit[gi] & (bus.mode ? all_avail : ~empty_w[gi]);

      assign lane_wdata = bus.mode ? bus.wr_data[0 +: DATA_WIDTH]
                                   : bus.wr_data[gi*DATA_WIDTH +: DATA_WIDTH];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (bus.clear) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
        end else begin
          if (wr_acc[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
          if (rd_acc[gi]) rd_ptr_d = rd_ptr_q + 1'b1;
          case ({wr_acc[gi], rd_acc[gi]})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
          endcase
        end
      end

      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
        end
      end

      // Storage and its read register stay reset-free so they map onto block RAM.
      always_ff @(posedge clk_i) begin
        if (wr_acc[gi]) mem[wr_ptr_q] <= lane_wdata;
        ram_rd_q <= mem[rd_ptr_q];
      end

      assign rd_data_w[gi*DATA_WIDTH +: DATA_WIDTH] = rd_valid_q[gi] ? ram_rd_q : '0;
      assign count_w[gi*CW +: CW] = cnt_q;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)      rd_valid_q <= '0;
    else if (bus.clear) rd_valid_q <= '0;
    else                rd_valid_q <= rd_acc;
  end

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_valid = rd_valid_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_w;

`ifdef COLUMN_PARALLEL_ERR_EN
  logic [NUM_COL-1:0] ovf_q;
  logic [NUM_COL-1:0] udf_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else if (bus.clear) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      ovf_q <= ovf_q | (wr_hit & full_w);
      udf_q <= udf_q | (rd_hit & empty_w);
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`endif
endmodule

// File: tb/tb_column_parallel_bank.sv
// Directed bench for column_parallel_bank: stimulus pushes expected reads, a monitor pops and compares.
module tb_column_parallel_bank;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NC = 4;
  localparam int CW = AW + 1;

  typedef struct {
    logic [NC-1:0]    v;
    logic [NC*DW-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  column_parallel_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_COL(NC)) bus ();

  column_parallel_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_COL(NC)) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  function automatic logic [NC*DW-1:0] lane(input int c, input logic [DW-1:0] val);
    logic [NC*DW-1:0] r;
    r = '0;
    r[c*DW +: DW] = val;
    return r;
  endfunction

  function automatic logic [CW-1:0] cnt(input int c);
    return bus.count[c*CW +: CW];
  endfunction

  // Monitor: reads issued before a rising edge must show right after it.
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_valid", {60'd0, bus.rd_valid}, {60'd0, e.v});
      chk("rd_data", {32'd0, bus.rd_data}, {32'd0, e.d});
      $display("read  valid=%b data=%h", bus.rd_valid, bus.rd_data);
    end else begin
      chk("idle_rd_valid", {60'd0, bus.rd_valid}, 64'd0);
      chk("idle_rd_data", {32'd0, bus.rd_data}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    bus.wr_req = '0;
    bus.rd_req = '0;
    bus.rd_en  = 1'b0;
    bus.clear  = 1'b0;
  endtask

  // One cycle of stimulus driven at the falling edge; ev/ed is the expected next-cycle read.
  task automatic cyc(input logic [NC-1:0] wreq, input logic [NC*DW-1:0] wdata, input logic ren,
                     input logic [NC-1:0] rreq, input logic [NC-1:0] ev, input logic [NC*DW-1:0] ed);
    exp_t e;
    bus.wr_req  = wreq;
    bus.wr_data = wdata;
    bus.rd_en   = ren;
    bus.rd_req  = rreq;
    if (ev != '0) begin
      e.v = ev;
      e.d = ed;
      exp_q.push_back(e);
      $display("issue rd_req=%b expect data=%h", rreq, ed);
    end else if (wreq != '0) begin
      $display("issue wr_req=%b data=%h", wreq, wdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.mode    = 1'b0;
    bus.wr_data = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("reset_empty", {60'd0, bus.empty}, 64'hF);
    chk("reset_full", {60'd0, bus.full}, 64'h0);
    chk("reset_count", {44'd0, bus.count}, 64'h0);
`ifdef COLUMN_PARALLEL_ERR_EN
    chk("reset_ovf", {60'd0, bus.ovf}, 64'h0);
    chk("reset_udf", {60'd0, bus.udf}, 64'h0);
`endif

    // Column 2 only
    cyc(4'b0100, lane(2, 8'h11), 1'b0, 4'b0000, 4'b0000, '0);
    cyc(4'b0100, lane(2, 8'h22), 1'b0, 4'b0000, 4'b0000, '0);
    cyc(4'b0100, lane(2, 8'h33), 1'b0, 4'b0000, 4'b0000, '0);
    chk("col2_count3", {59'd0, cnt(2)}, 64'd3);
    chk("col2_empty", {60'd0, bus.empty}, 64'hB);
    cyc('0, '0, 1'b1, 4'b0100, 4'b0100, lane(2, 8'h11));
    cyc('0, '0, 1'b1, 4'b0100, 4'b0100, lane(2, 8'h22));
    cyc('0, '0, 1'b1, 4'b0100, 4'b0100, lane(2, 8'h33));
    chk("col2_count0", {59'd0, cnt(2)}, 64'd0);

    // Fill column 0, overflow attempt, drain, then wrap
    for (int i = 0; i < 16; i++) cyc(4'b0001, lane(0, 8'(i)), 1'b0, '0, '0, '0);
    chk("col0_full", {60'd0, bus.full}, 64'h1);
    chk("col0_count16", {59'd0, cnt(0)}, 64'd16);
    cyc(4'b0001, lane(0, 8'hAA), 1'b1, 4'b0000, '0, '0);
    chk("col0_drop_count", {59'd0, cnt(0)}, 64'd16);
`ifdef COLUMN_PARALLEL_ERR_EN
    chk("col0_ovf", {60'd0, bus.ovf}, 64'h1);
`endif
    for (int i = 0; i < 16; i++) cyc('0, '0, 1'b1, 4'b0001, 4'b0001, lane(0, 8'(i)));
    chk("col0_drained", {60'd0, bus.empty}, 64'hF);
    for (int i = 0; i < 8; i++) cyc(4'b0001, lane(0, 8'h80 + 8'(i)), 1'b0, '0, '0, '0);
    for (int i = 0; i < 8; i++) cyc('0, '0, 1'b1, 4'b0001, 4'b0001, lane(0, 8'h80 + 8'(i)));
    cyc('0, '0, 1'b1, 4'b0001, '0, '0);
    chk("col0_empty_read_count", {59'd0, cnt(0)}, 64'd0);
`ifdef COLUMN_PARALLEL_ERR_EN
    chk("col0_udf", {60'd0, bus.udf}, 64'h1);
`endif

    // Column 1: simultaneous read/write at count 5, then a read with rd_en low
    for (int i = 0; i < 5; i++) cyc(4'b0010, lane(1, 8'h40 + 8'(i)), 1'b0, '0, '0, '0);
    chk("col1_count5", {59'd0, cnt(1)}, 64'd5);
    cyc(4'b0010, lane(1, 8'h45), 1'b1, 4'b0010, 4'b0010, lane(1, 8'h40));
    chk("col1_rw_count", {59'd0, cnt(1)}, 64'd5);
    cyc('0, '0, 1'b0, 4'b0010, '0, '0);
    chk("col1_rden0_count", {59'd0, cnt(1)}, 64'd5);
    for (int i = 1; i < 6; i++) cyc('0, '0, 1'b1, 4'b0010, 4'b0010, lane(1, 8'h40 + 8'(i)));
    chk("col1_drained", {59'd0, cnt(1)}, 64'd0);

    // Lock-step broadcast
    bus.mode = 1'b1;
    cyc(4'b1111, 32'hEEEEEE5A, 1'b0, '0, '0, '0);
    chk("ls_counts", {44'd0, bus.count}, {44'd0, 5'd1, 5'd1, 5'd1, 5'd1});
    cyc('0, '0, 1'b1, 4'b0001, 4'b1111, 32'h5A5A5A5A);
    chk("ls_empty", {60'd0, bus.empty}, 64'hF);
    bus.mode = 1'b0;
    cyc(4'b0111, 32'h00030201, 1'b0, '0, '0, '0);
    bus.mode = 1'b1;
    cyc('0, '0, 1'b1, 4'b1111, '0, '0);
    chk("ls_stall_counts", {44'd0, bus.count}, {44'd0, 5'd0, 5'd1, 5'd1, 5'd1});
    bus.mode = 1'b0;
    cyc('0, '0, 1'b1, 4'b0111, 4'b0111, 32'h00030201);
    chk("ls_after_drain", {60'd0, bus.empty}, 64'hF);

    // Clear overrides same-cycle requests
    for (int i = 0; i < 7; i++) cyc(4'b0001, lane(0, 8'h70 + 8'(i)), 1'b0, '0, '0, '0);
    chk("clr_count7", {59'd0, cnt(0)}, 64'd7);
    bus.clear = 1'b1;
    cyc(4'b0001, lane(0, 8'h77), 1'b1, 4'b0001, '0, '0);
    chk("clr_count0", {59'd0, cnt(0)}, 64'd0);
    chk("clr_empty", {60'd0, bus.empty}, 64'hF);
`ifdef COLUMN_PARALLEL_ERR_EN
    chk("clr_ovf", {60'd0, bus.ovf}, 64'h0);
    chk("clr_udf", {60'd0, bus.udf}, 64'h0);
`endif

    // Reset mid-burst drops the in-flight read
    for (int i = 1; i < 4; i++) cyc(4'b0010, lane(1, 8'h90 + 8'(i)), 1'b0, '0, '0, '0);
    cyc('0, '0, 1'b1, 4'b0010, 4'b0010, lane(1, 8'h91));
    bus.rd_en  = 1'b1;
    bus.rd_req = 4'b0010;
    bus.wr_req = 4'b0010;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_count", {44'd0, bus.count}, 64'h0);
    chk("rst_empty", {60'd0, bus.empty}, 64'hF);
    chk("rst_full", {60'd0, bus.full}, 64'h0);
    chk("rst_rd_valid", {60'd0, bus.rd_valid}, 64'h0);
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Recovery after reset
    cyc(4'b1000, lane(3, 8'hC3), 1'b0, '0, '0, '0);
    cyc('0, '0, 1'b1, 4'b1000, 4'b1000, lane(3, 8'hC3));
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/column_parallel_bank.md
Name: column_parallel_bank

Overview:
Multi-column activation buffer. NUM_COL independent circular queues, one per column, each 2^ADDR_WIDTH entries deep. It feeds the PE array one word per column per cycle. It generalises the single-column RAM/zero-gate buffer to N columns, with real FIFO pointers, full/empty tracking, a lock-step broadcast mode and a registered valid-qualified read path. It sits between the memory controller write side and the PE-array operand inputs.

Parameters:
DATA_WIDTH, 8, bits per word
ADDR_WIDTH, 4, log2 of per-column depth (depth = 2^ADDR_WIDTH)
NUM_COL, 4, number of parallel columns

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low
mode  in  1  0 = independent columns, 1 = lock-step broadcast
clear  in  1  synchronous flush of all pointers and counts
wr_req  in  NUM_COL  per-column write request
wr_data  in  NUM_COL*DATA_WIDTH  per-column write data; column c at [c*DATA_WIDTH +: DATA_WIDTH]
rd_en  in  1  global read enable (gates all reads)
rd_req  in  NUM_COL  per-column read request
rd_data  out  NUM_COL*DATA_WIDTH  per-column read data; zero when lane not valid
rd_valid  out  NUM_COL  per-column read-data valid
full  out  NUM_COL  column holds 2^ADDR_WIDTH entries
empty  out  NUM_COL  column holds 0 entries
count  out  NUM_COL*(ADDR_WIDTH+1)  per-column occupancy

Behaviour:
- Reset (async, reset=0): all wr/rd pointers and counts = 0, rd_valid = 0, rd_data = 0, empty = all 1, full = all 0. Storage contents are not reset.
- Per-column state: wr_ptr and rd_ptr (ADDR_WIDTH bits, wrap modulo 2^ADDR_WIDTH) and cnt (ADDR_WIDTH+1 bits). full = (cnt == 2^ADDR_WIDTH); empty = (cnt == 0). Both are combinational from registered cnt.
- Mode 0, write accept: wr_acc[c] = wr_req[c] & ~full[c]. On accept: mem[c][wr_ptr] <= lane c data; wr_ptr++.
- Mode 0, read accept: rd_acc[c] = rd_en & rd_req[c] & ~empty[c].
- Mode 1 (lock-step): only wr_req[0] and rd_req[0] are used; the other request bits are ignored.
  - Write: wr_acc = wr_req[0] & no column full. On accept, lane 0 data is written to every column.
  - Read: rd_acc = rd_en & rd_req[0] & no column empty. On accept, all columns read together.
- Read latency is 1 cycle. Cycle N accept gives rd_valid[c] = 1 and rd_data lane c = mem[c][rd_ptr at N] in cycle N+1. A non-accepted lane shows rd_valid = 0 and rd_data lane = 0 in N+1. The output data register is zero-gated by valid.
- cnt update per column: +1 on write only, -1 on read only, unchanged on both or neither.
- Boundary cases:
  - Write while full is dropped, even if a read is accepted in the same cycle.
  - Read while empty is rejected, even if a write is accepted in the same cycle; no same-cycle bypass.
  - Simultaneous read and write when 0 < cnt < full: both accepted, cnt unchanged.
  - Pointer wrap from 2^ADDR_WIDTH-1 to 0 is seamless.
- clear = 1: next edge sets pointers and counts to 0 and rd_valid to 0, overriding any same-cycle requests.
- mode change: takes effect on the next accept decision. Pointers are kept, so columns can start mode 1 with unequal counts; lock-step then stalls until all columns meet the condition.
- Reset asserted mid-operation: immediate return to reset values; any in-flight rd_valid is lost.

Optional Feature:
COLUMN_PARALLEL_ERR_EN.
- Defined: adds outputs ovf (NUM_COL) and udf (NUM_COL), both sticky.
  - ovf[c] sets when wr_req[c] is high while full[c]. In mode 1, column 0's request is applied to all full columns.
  - udf[c] sets when rd_en & rd_req[c] is high while empty[c].
  - Both clear only on reset or clear.
- Not defined: ports are absent; dropped requests are silent.

Test Plan:
- Reset, then idle: empty = 4'hF, full = 0, rd_valid = 0, rd_data = 0, every count = 0.
- Mode 0: write 0x11, 0x22, 0x33 to column 2 only, then read 3 times with rd_en = 1 -> column 2 rd_data gives 0x11, 0x22, 0x33 each one cycle after accept; other lanes stay 0 with rd_valid = 0; count[2] goes 3 -> 0.
- Fill column 0 with 16 writes (0x00 to 0x0F), then a 17th write of 0xAA -> full[0] = 1 and the write is dropped (ovf[0] = 1 if ERR_EN). Reading 16 words returns 0x00 to 0x0F. Wrap check: 8 more writes then 8 reads return correct data.
- Simultaneous read and write at count = 5: count stays 5, data order preserved. Read with rd_en = 0 -> no accept, rd_valid = 0.
- Mode 1: wr_req[0] with lane 0 data = 0x5A -> all columns count = 1; rd_req[0] -> all lanes 0x5A with rd_valid = 4'hF. With column 3 empty, a lock-step read stalls: rd_valid = 0, no pointer moves.
- clear asserted together with wr_req and rd_req at count = 7 -> next cycle count = 0, empty = 1, rd_valid = 0. Reset pulsed mid-burst -> outputs return to reset values immediately.
